// File: rtl/mac5_pkg.sv
// Shared definitions for the MAC5 accumulation stage.
// Holds the FSM state encoding, the multiplier term width and default sizes.
// Imported by every file of the accumulator.
package mac5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Multiplier result width: carry-out on top of the 8-bit product.
  localparam int MAC5_TERM_W = 9;

  localparam int ACC_W_DEFAULT = 16;
  localparam int LEN_W_DEFAULT = 8;

endpackage

// File: rtl/mac5_sat_add.sv
// Saturating unsigned add of one 9-bit multiplier term into the accumulator.
// Purely combinational, no latency.
// No handshake; overflow clamps the sum to all-ones and raises ovf.
module mac5_sat_add
  import mac5_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT  // must be at least MAC5_TERM_W
) (
  input  logic [ACC_W-1:0]       acc,
  input  logic [MAC5_TERM_W-1:0] term,
  output logic [ACC_W-1:0]       sum,
  output logic                   ovf
);

  // One extra bit is enough to catch overflow because term never exceeds acc's range.
  logic [ACC_W:0] raw;

  // Widen, add, then clamp on carry-out.
  always_comb begin
    raw = {1'b0, acc} + {{(ACC_W + 1 - MAC5_TERM_W){1'b0}}, term};
    ovf = raw[ACC_W];
    sum = ovf ? '1 : raw[ACC_W-1:0];
  end

endmodule

// File: rtl/mac5_accumulator.sv
// Accumulates cfg_len multiplier terms with saturation and presents the sum.
// Latency: result visible the cycle after the last accepted beat.
// Holds the result in HOLD until out_ready; in_ready only while accumulating.
module mac5_accumulator
  import mac5_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             sat;

  logic             beat;
  logic             last_beat;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt == LEN_W'(1));

  mac5_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc  (acc),
    .term ({in_carry, in_product}),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a zero-length job skips straight to HOLD; start elsewhere is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (cfg_len == '0) ? HOLD : ACC;
      ACC:  if (last_beat) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // Datapath: counter, accumulator, sticky sat and the registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      sat     <= 1'b0;
      out_sum <= '0;
      out_sat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= cfg_len;
            acc <= '0;
            sat <= 1'b0;
            if (cfg_len == '0) begin
              out_sum <= '0;
              out_sat <= 1'b0;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc <= add_sum;
            sat <= sat | add_ovf;
            cnt <= cnt - LEN_W'(1);
            // Capture the final sum including this beat so HOLD shows it next cycle.
            if (last_beat) begin
              out_sum <= add_sum;
              out_sat <= sat | add_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mac5_accumulator.md
# mac5_accumulator

Sequential accumulation stage directly downstream of the MAC5 Wallace-tree multiplier. Each beat takes one multiplier result (8-bit product plus carry-out, a 9-bit unsigned term) and adds it into a saturating accumulator. After a programmed number of beats it presents the dot-product sum on a valid/ready output port. Together the multiplier and this block form the complete MAC5 multiply-accumulate datapath.

## Interface
- ACC_W, 16, accumulator and result width in bits; must be ≥ 9
- LEN_W, 8, width of the beat-count configuration
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- start  in  1  begin a new accumulation; honoured only in IDLE
- cfg_len  in  LEN_W  number of beats to accumulate; sampled with start
- in_valid  in  1  multiplier result valid
- in_ready  out  1  block accepts a term this cycle
- in_product  in  8  multiplier product[7:0]
- in_carry  in  1  multiplier carry-out; term = {in_carry, in_product}
- out_valid  out  1  result valid
- out_ready  in  1  downstream consumes the result
- out_sum  out  ACC_W  accumulated sum, saturated
- out_sat  out  1  saturation occurred during this accumulation
- busy  out  1  high in every state except IDLE

## Operation
- The FSM has three states: IDLE, ACC and HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - When start=1, the block latches cfg_len into the beat counter and clears the accumulator and the sat flag.
  - If cfg_len≠0, go to ACC. If cfg_len=0, go directly to HOLD with sum 0 and sat 0.
- ACC:
  - in_ready=1.
  - On each in_valid&&in_ready:
    - acc ← sat_add(acc, zero-extended 9-bit term).
    - The counter decrements.
    - The sat flag is sticky-ORed with the adder overflow.
  - On the beat where the counter reaches 0, go to HOLD.
  - Cycles with in_valid=0 do not change state.
- HOLD:
  - out_valid=1. out_sum and out_sat are driven from registers and stay stable while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready, go to IDLE.
- Arithmetic:
  - Unsigned.
  - If the sum exceeds 2^ACC_W−1, it clamps to 2^ACC_W−1 and sat is set.
  - Once clamped, the accumulator stays at 2^ACC_W−1 for the remaining beats. Remaining beats are still consumed.
- start asserted outside IDLE is ignored; it is neither queued nor aborts the run.
- Inputs presented outside ACC are not accepted (in_ready=0).

## Timing
- Reset (rst_n=0 at a clock edge) forces the following, regardless of state, including mid-accumulation or mid-HOLD:
  - state IDLE
  - acc=0, counter=0, out_sum=0, out_sat=0
  - out_valid=0, in_ready=0, busy=0
- Reset is synchronous only: no output changes before the edge.
- start→ACC: 1 cycle. in_ready rises in the cycle after start is sampled.
- Final accepted beat at edge T: out_valid=1 and out_sum (including that beat) visible after edge T. That is 1-cycle latency from last beat to result.
- cfg_len=0: out_valid=1 one cycle after start, out_sum=0.
- Minimum turnaround:
  - The HOLD→IDLE handshake takes one edge.
  - A new start is accepted in the following IDLE cycle.
  - This gives one bubble cycle between runs.
- Throughput in ACC: one term per cycle when in_valid is held high.

## Structure
- Shared package mac5_pkg holds:
  - FSM state enum {IDLE, ACC, HOLD}
  - constant MAC5_TERM_W = 9
  - default ACC_W / LEN_W values
- One sub-module, mac5_sat_add:
  - combinational ACC_W + MAC5_TERM_W unsigned adder
  - returns the clamped sum and an overflow bit
- Top level: FSM, beat counter, accumulator and sat registers, output registers.

## Test plan
- Reset then start with cfg_len=4 and terms 9,9,9,9 (product=9, carry=0) back-to-back → out_valid one cycle after the 4th beat, out_sum=36, out_sat=0.
- cfg_len=3, terms 256 (carry=1, product=0), 5, 0, with in_valid gaps of 2 cycles between beats → exactly 3 beats accepted, out_sum=261; busy high throughout.
- ACC_W=9, cfg_len=3, terms 300, 300, 1 → out_sum=511, out_sat=1, all 3 beats consumed.
- cfg_len=0 → out_valid one cycle after start, out_sum=0. Hold out_ready=0 for 5 cycles → out_sum and out_valid stable; out_ready=1 → IDLE next cycle.
- start pulsed during ACC after 2 of 5 beats → ignored; the original run completes with 5 beats.
- rst_n=0 for one cycle after 2 of 4 beats → all outputs zero and state IDLE at the next cycle. A new run with cfg_len=1 and term 7 → out_sum=7.
